// File: rtl/reg6_serial_tx.sv
// Parallel-in, serial-out transmitter: frames a WIDTH-bit word as start bit,
// data LSB first and stop bit, with each bit held for CLKS_PER_BIT clocks.
module reg6_serial_tx #(
    parameter int WIDTH        = 6,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic             load,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             period_end;

    assign period_end = (cyc_cnt == CYC_LAST);
    assign shreg_next = shreg >> 1;

    // Outputs are driven from the same block as the state so that sout and
    // busy change on the accepting edge itself, with no combinational path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shift register and counters are plain flops, not a
            // memory, so resetting them is cheap and keeps a restart clean.
            state   <= IDLE;
            shreg   <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            sout    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; every branch reads
            // the values from before this edge, which is what the timing needs.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    busy <= 1'b0;
                    if (load) begin
                        shreg   <= I;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        sout    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end

                START: begin
                    if (period_end) begin
                        cyc_cnt <= '0;
                        sout    <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (period_end) begin
                        cyc_cnt <= '0;
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            sout  <= 1'b1;
                            state <= STOP;
                        end else begin
                            sout <= shreg_next[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (period_end) begin
                        cyc_cnt <= '0;
                        sout    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                default: begin
                    sout  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg6_serial_tx.sv
// Self-checking bench for reg6_serial_tx: two instances (4 and 1 clocks per
// bit) compared cycle by cycle against an ideal framed-line model.
module tb_reg6_serial_tx;

    localparam int W           = 6;
    localparam int KIND_NONE   = 0;
    localparam int KIND_CHANGE = 1;
    localparam int KIND_LOAD   = 2;
    localparam int KIND_RESET  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] i4, i1;
    logic         load4, load1;
    logic         sout4, busy4, done4;
    logic         sout1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg6_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .I    (i4),
        .load (load4),
        .sout (sout4),
        .busy (busy4),
        .done (done4)
    );

    reg6_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .I    (i1),
        .load (load1),
        .sout (sout1),
        .busy (busy1),
        .done (done1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [2:0] obs(input bit fast);
        return fast ? {sout1, busy1, done1} : {sout4, busy4, done4};
    endfunction

    task automatic drive(input bit fast, input logic [W-1:0] word, input logic ld);
        if (fast) begin
            i1    = word;
            load1 = ld;
        end else begin
            i4    = word;
            load4 = ld;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal line level during bit period b of a frame carrying word.
    function automatic logic line_bit(input logic [W-1:0] word, input int b);
        if (b == 0) return 1'b0;
        if (b <= W) return word[b-1];
        return 1'b1;
    endfunction

    // Runs one frame on the chosen instance, comparing every cycle. Optional
    // mid-frame disturbance at cycle 'at'; 'chain' raises load in the done
    // cycle so the next call (preloaded=1) starts on the following edge.
    task automatic run_frame(input string name, input bit fast, input logic [W-1:0] word,
                             input bit preloaded, input int kind, input int at,
                             input bit chain, input logic [W-1:0] chain_word,
                             input logic [W-1:0] alt);
        int           c;
        int           len;
        logic [W-1:0] rx;
        logic [2:0]   got;
        logic [2:0]   exp;
        c   = fast ? 1 : 4;
        len = (W + 2) * c;
        rx  = '0;
        if (!preloaded) drive(fast, word, 1'b1);
        tick();
        drive(fast, word, 1'b0);
        for (int j = 0; j < len; j++) begin
            exp = {line_bit(word, j / c), 1'b1, 1'b0};
            got = obs(fast);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: sout/busy/done=%b expected %b", name, j, got, exp);
            end
            if ((j % c) == (c / 2) && (j / c) >= 1 && (j / c) <= W) rx[j/c-1] = got[2];
            if (kind == KIND_RESET && j == at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                got = obs(fast);
                checks++;
                if (got !== 3'b100) begin
                    errors++;
                    $display("FAIL %s reset edge: sout/busy/done=%b expected 100", name, got);
                end
                for (int q = 0; q < len; q++) begin
                    tick();
                    got = obs(fast);
                    checks++;
                    if (got !== 3'b100) begin
                        errors++;
                        $display("FAIL %s after abort %0d: sout/busy/done=%b expected 100", name, q, got);
                    end
                end
                return;
            end
            if (kind == KIND_CHANGE && j == at) drive(fast, alt, 1'b0);
            if (kind == KIND_LOAD) begin
                if (j == at) drive(fast, word, 1'b1);
                else if (j == at + 1) drive(fast, word, 1'b0);
            end
            tick();
        end
        got = obs(fast);
        checks++;
        if (got !== 3'b101) begin
            errors++;
            $display("FAIL %s end of frame: sout/busy/done=%b expected 101", name, got);
        end
        checks++;
        if (rx !== word) begin
            errors++;
            $display("FAIL %s receiver word: got %0d expected %0d", name, rx, word);
        end
        if (chain) begin
            drive(fast, chain_word, 1'b1);
        end else begin
            tick();
            got = obs(fast);
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL %s idle after done: sout/busy/done=%b expected 100", name, got);
            end
        end
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst_n = 1'b0;
        drive(1'b0, 6'd45, 1'b1);
        drive(1'b1, 6'd0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            got = obs(1'b0);
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL reset dut4 cycle %0d: sout/busy/done=%b expected 100", n, got);
            end
            got = obs(1'b1);
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL reset dut1 cycle %0d: sout/busy/done=%b expected 100", n, got);
            end
        end
        rst_n = 1'b1;
        run_frame("reset_release", 1'b0, 6'd45, 1'b1, KIND_NONE, 0, 1'b0, '0, '0);
    endtask

    task automatic test_single_63();
        run_frame("single_63", 1'b0, 6'd63, 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
    endtask

    task automatic test_bit_order();
        run_frame("order_21", 1'b1, 6'd21, 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
        run_frame("order_34", 1'b1, 6'd34, 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
        run_frame("order_34_slow", 1'b0, 6'd34, 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
    endtask

    task automatic test_capture();
        run_frame("capture_slow", 1'b0, 6'd21, 1'b0, KIND_CHANGE, int'($urandom_range(0, 30)),
                  1'b0, '0, 6'd63);
        run_frame("capture_fast", 1'b1, 6'd21, 1'b0, KIND_CHANGE, 2, 1'b0, '0, 6'd63);
    endtask

    task automatic test_ignored_load();
        run_frame("ignored_load_slow", 1'b0, 6'd21, 1'b0, KIND_LOAD, int'($urandom_range(0, 30)),
                  1'b0, '0, '0);
        run_frame("ignored_load_fast", 1'b1, 6'd21, 1'b0, KIND_LOAD, 6, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_21", 1'b1, 6'd21, 1'b0, KIND_NONE, 0, 1'b1, 6'd34, '0);
        run_frame("b2b_34", 1'b1, 6'd34, 1'b1, KIND_NONE, 0, 1'b0, '0, '0);
        run_frame("b2b_slow_a", 1'b0, 6'd21, 1'b0, KIND_NONE, 0, 1'b1, 6'd34, '0);
        run_frame("b2b_slow_b", 1'b0, 6'd34, 1'b1, KIND_NONE, 0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame("abort_63", 1'b0, 6'd63, 1'b0, KIND_RESET, int'($urandom_range(4, 27)),
                  1'b0, '0, '0);
        run_frame("after_abort", 1'b0, W'($urandom), 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
        run_frame("abort_fast", 1'b1, 6'd63, 1'b0, KIND_RESET, 3, 1'b0, '0, '0);
        run_frame("after_abort_fast", 1'b1, 6'd42, 1'b0, KIND_NONE, 0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        bit           fast;
        int           nfr;
        int           len;
        logic [W-1:0] w;
        logic [W-1:0] nw;
        for (int b = 0; b < 12; b++) begin
            fast = 1'($urandom_range(0, 1));
            nfr  = int'($urandom_range(1, 3));
            len  = (W + 2) * (fast ? 1 : 4);
            w    = W'($urandom);
            for (int f = 0; f < nfr; f++) begin
                nw = W'($urandom);
                run_frame("random", fast, w, f != 0, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, len - 2)), f != nfr - 1, nw, ~w);
                w = nw;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i4    = '0;
        i1    = '0;
        load4 = 1'b0;
        load1 = 1'b0;
        test_reset();
        test_single_63();
        test_bit_order();
        test_capture();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
